// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: accepts bitstream words over valid/ready and
// shifts them LSB-first into the fabric chain, stopping after exactly CHAIN_LEN bits.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              busy,
    output logic              done
);

    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     wbits;
    logic [RW-1:0]     remaining;
    logic              accept;
    logic              last_bit;
    logic [RW-1:0]     rem_after;
    logic [BW-1:0]     load_bits;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new word is only requested once the current one is on its last bit,
    // and never when the bits already held cover the rest of the chain.
    always_comb begin
        prog_en    = (state == LOAD) && (wbits != '0);
        busy       = (state == LOAD);
        done       = (state == DONE);
        ccff_head  = prog_en ? sreg[0] : 1'b0;
        word_ready = (state == LOAD) && !abort
                     && ((wbits == '0) || ((wbits == BW'(1)) && prog_en))
                     && (32'(remaining) > 32'(wbits));
    end

    // The final word is trimmed to the bits the chain still needs.
    always_comb begin
        accept    = word_valid && word_ready;
        last_bit  = prog_en && (remaining == RW'(1));
        rem_after = remaining - RW'(prog_en);
        if (32'(rem_after) >= WORD_W) begin
            load_bits = BW'(WORD_W);
        end else begin
            load_bits = BW'(rem_after);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sreg      <= '0;
            wbits     <= '0;
            remaining <= '0;
        end else if (state != LOAD) begin
            if (start) begin
                wbits     <= '0;
                remaining <= RW'(CHAIN_LEN);
            end
        end else if (abort) begin
            wbits     <= '0;
            remaining <= '0;
        end else begin
            if (prog_en) begin
                remaining <= remaining - RW'(1);
            end
            if (accept) begin
                sreg  <= word_data;
                wbits <= load_bits;
            end else if (prog_en) begin
                sreg  <= sreg >> 1;
                wbits <= wbits - BW'(1);
            end
        end
    end

endmodule
